// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared widths and fetch-entry type for the fetch stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Width of an occupancy counter able to hold the value `depth` itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue_if.sv
// ============================================================================
// Module : fetch_queue_if
// Brief  : PC, instruction-memory and decode handshake bundle of fetch_queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface fetch_queue_if
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);

    localparam int CNT_W = cnt_width(DEPTH);

    logic [PC_W-1:0]   pc_q;
    logic              pc_en;
    logic              redirect;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rden;
    logic [DATA_W-1:0] imem_q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [PC_W-1:0]   out_pc;
    logic [CNT_W-1:0]  occupancy;

    modport master (
        input  pc_q, redirect, imem_q, out_ready,
        output pc_en, imem_addr, imem_rden, out_valid, out_instr, out_pc, occupancy
    );

    modport slave (
        output pc_q, redirect, imem_q, out_ready,
        input  pc_en, imem_addr, imem_rden, out_valid, out_instr, out_pc, occupancy
    );

endinterface

`default_nettype wire

// File: rtl/fetch_queue_sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Power-of-two FIFO with flush, occupancy count and head read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push,
    input  wire logic                   pop,
    input  wire logic                   flush,
    input  wire logic [WIDTH-1:0]       wr_data,
    output logic      [WIDTH-1:0]       head,
    output logic      [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    // Flush takes priority over any same-cycle push or pop.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Brief  : Credit-based instruction fetch with 1-cycle imem and decode FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fetch_queue_if.master  bus
);

    localparam int               CNT_W    = cnt_width(DEPTH);
    localparam int               ENTRY_W  = PC_W + DATA_W;
    localparam logic [CNT_W:0]   FULL_LVL = (CNT_W + 1)'(DEPTH);

    logic                 inflight;
    logic [PC_W-1:0]      inflight_pc;
    logic [CNT_W-1:0]     count;
    logic [CNT_W:0]       used;
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic                 valid;
    logic [ENTRY_W-1:0]   head;

    // Outstanding reads reserve a slot, so a response always finds room.
    assign used  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue = rst && !bus.redirect && (used < FULL_LVL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight    <= issue;
            inflight_pc <= bus.pc_q;
        end
    end

    assign push  = inflight && !bus.redirect;
    assign valid = rst && (count != '0) && !bus.redirect;
    assign pop   = valid && bus.out_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (bus.redirect),
        .wr_data ({inflight_pc, bus.imem_q}),
        .head    (head),
        .count   (count)
    );

    assign bus.imem_addr = bus.pc_q[ADDR_W-1:0];
    assign bus.imem_rden = issue;
    assign bus.pc_en     = issue || (rst && bus.redirect);
    assign bus.out_valid = valid;
    assign bus.out_instr = (count != '0) ? head[DATA_W-1:0] : '0;
    assign bus.out_pc    = (count != '0) ? head[ENTRY_W-1:DATA_W] : '0;
    assign bus.occupancy = count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module : tb_fetch_queue
// Brief  : Vector table plus scoreboard bench for fetch_queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;
    import cpu_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic        clk;
    logic        rst;
    logic [31:0] target;

    int vectors     = 0;
    int miscompares = 0;

    fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {a, 4'h5, ~a, 4'hA};
    endfunction

    // Environment: PC register and 1-cycle synchronous instruction memory.
    always @(posedge clk or negedge rst) begin
        if (!rst)             bus.pc_q <= '0;
        else if (bus.pc_en)   bus.pc_q <= bus.redirect ? target : bus.pc_q + 32'd1;
    end

    always @(posedge clk) begin
        if (bus.imem_rden) bus.imem_q <= mem_word(bus.imem_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: queue holds PCs of fetches issued and not yet delivered.
    logic [31:0] sq [$];
    int          infl;
    logic [31:0] exp_next;

    always @(negedge clk) begin
        int  e_occ;
        bit  e_issue;
        bit  e_valid;
        logic [31:0] f;
        #2;
        if (!rst) begin
            sq.delete();
            infl     = 0;
            exp_next = '0;
        end else begin
            e_occ   = sq.size() - infl;
            e_issue = !bus.redirect && (sq.size() < DEPTH);
            e_valid = (e_occ > 0) && !bus.redirect;
            chk("sb_pc_q",  bus.pc_q, exp_next);
            chk("sb_addr",  bus.imem_addr, bus.pc_q[11:0]);
            chk("sb_rden",  bus.imem_rden, e_issue);
            chk("sb_pc_en", bus.pc_en, e_issue || bus.redirect);
            chk("sb_valid", bus.out_valid, e_valid);
            chk("sb_occ",   bus.occupancy, e_occ);
            if (bus.out_valid && bus.out_ready && sq.size() > 0) begin
                f = sq.pop_front();
                chk("sb_out_pc",    bus.out_pc, f);
                chk("sb_out_instr", bus.out_instr, mem_word(f[11:0]));
            end
            if (bus.redirect) begin
                sq.delete();
                exp_next = target;
                infl     = 0;
            end else if (e_issue) begin
                sq.push_back(bus.pc_q);
                exp_next = bus.pc_q + 32'd1;
                infl     = 1;
            end else begin
                infl = 0;
            end
        end
    end

    typedef struct {
        bit          rst_pre;
        bit          ready;
        bit          redir;
        logic [31:0] tgt;
        bit          e_rden;
        bit          e_pcen;
        bit          e_valid;
        logic [31:0] e_pcq;
        logic [31:0] e_outpc;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input bit rp, input bit rdy, input bit rd, input logic [31:0] t,
                       input bit er, input bit ep, input bit ev,
                       input logic [31:0] pq, input logic [31:0] op, input logic [2:0] oc);
        vec_t v;
        v.rst_pre = rp; v.ready = rdy; v.redir = rd; v.tgt = t;
        v.e_rden = er; v.e_pcen = ep; v.e_valid = ev;
        v.e_pcq = pq; v.e_outpc = op; v.e_occ = oc;
        vecs.push_back(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_pc_en"}, bus.pc_en, 1'b0);
        chk({tag, "_rden"},  bus.imem_rden, 1'b0);
        chk({tag, "_instr"}, bus.out_instr, '0);
        chk({tag, "_out_pc"}, bus.out_pc, '0);
        chk({tag, "_occ"},   bus.occupancy, '0);
    endtask

    // Ends on a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        bus.redirect  = 1'b1;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        bus.redirect = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        bus.redirect  = 1'b0;
        target        = '0;

        // Streaming with out_ready=1
        add(1,1,0,0, 1,1,0, 0,0,0);
        add(0,1,0,0, 1,1,0, 1,0,0);
        add(0,1,0,0, 1,1,1, 2,0,1);
        add(0,1,0,0, 1,1,1, 3,1,1);
        add(0,1,0,0, 1,1,1, 4,2,1);
        // Backpressure until full, then release
        add(1,0,0,0, 1,1,0, 0,0,0);
        add(0,0,0,0, 1,1,0, 1,0,0);
        add(0,0,0,0, 1,1,1, 2,0,1);
        add(0,0,0,0, 1,1,1, 3,0,2);
        add(0,0,0,0, 0,0,1, 4,0,3);
        add(0,0,0,0, 0,0,1, 4,0,4);
        add(0,0,0,0, 0,0,1, 4,0,4);
        add(0,1,0,0, 0,0,1, 4,0,4);
        add(0,1,0,0, 1,1,1, 4,1,3);
        add(0,1,0,0, 1,1,1, 5,2,2);
        add(0,1,0,0, 1,1,1, 6,3,2);
        add(0,1,0,0, 1,1,1, 7,4,2);
        // Redirect with occupancy 3, a read in flight and out_ready high
        add(1,0,0,0,        1,1,0, 0,0,0);
        add(0,0,0,0,        1,1,0, 1,0,0);
        add(0,0,0,0,        1,1,1, 2,0,1);
        add(0,0,0,0,        1,1,1, 3,0,2);
        add(0,1,1,32'h40,   0,1,0, 4,0,3);
        add(0,1,0,0,        1,1,0, 32'h40,0,0);
        add(0,1,0,0,        1,1,0, 32'h41,0,0);
        add(0,1,0,0,        1,1,1, 32'h42,32'h40,1);
        add(0,1,0,0,        1,1,1, 32'h43,32'h41,1);

        foreach (vecs[i]) begin
            if (vecs[i].rst_pre) do_reset();
            else                 @(negedge clk);
            bus.out_ready = vecs[i].ready;
            bus.redirect  = vecs[i].redir;
            target        = vecs[i].tgt;
            #1;
            chk($sformatf("v%0d_rden", i),  bus.imem_rden, vecs[i].e_rden);
            chk($sformatf("v%0d_pc_en", i), bus.pc_en, vecs[i].e_pcen);
            chk($sformatf("v%0d_valid", i), bus.out_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_pc_q", i),  bus.pc_q, vecs[i].e_pcq);
            chk($sformatf("v%0d_occ", i),   bus.occupancy, vecs[i].e_occ);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_out_pc", i), bus.out_pc, vecs[i].e_outpc);
                chk($sformatf("v%0d_instr", i),  bus.out_instr, mem_word(vecs[i].e_outpc[11:0]));
            end
        end

        // Reset asserted mid-stream with a read in flight
        @(negedge clk);
        bus.redirect = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst_a");
        @(negedge clk);
        #1;
        check_reset_outputs("mid_rst_b");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel0_rden",  bus.imem_rden, 1'b1);
        chk("rel0_occ",   bus.occupancy, '0);
        chk("rel0_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("rel1_occ",   bus.occupancy, '0);
        chk("rel1_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("rel2_occ",    bus.occupancy, 3'd1);
        chk("rel2_valid",  bus.out_valid, 1'b1);
        chk("rel2_out_pc", bus.out_pc, 32'd0);
        chk("rel2_instr",  bus.out_instr, mem_word(12'd0));

        // Random backpressure and redirects, checked by the scoreboard
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.redirect  = ($urandom_range(0, 19) == 0);
            target        = $urandom;
        end
        @(negedge clk);
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Each cycle it decides whether to fetch the word at the current PC, and drives the PC register's advance-enable.
- It issues reads to a synchronous instruction memory with 1-cycle read latency and buffers returned instructions with their PC in a small FIFO.
- It presents instructions to decode with a valid/ready handshake; a redirect from the branch/jump logic flushes all queued and in-flight fetches.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 12: instruction memory word-address width.
- DATA_W, 32: instruction width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- pc_q  input  32  current word-addressed PC from the PC register.
- pc_en  output  1  advance/load enable to the PC register.
- redirect  input  1  taken branch/jump/jr this cycle; the PC register loads the target when pc_en is high.
- imem_addr  output  ADDR_W  read address, equal to pc_q[ADDR_W-1:0].
- imem_rden  output  1  read strobe.
- imem_q  input  DATA_W  read data, valid the cycle after imem_rden.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode accepts the head entry.
- out_instr  output  DATA_W  head instruction.
- out_pc  output  32  PC of the head instruction.
- occupancy  output  log2(DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO count, read pointer and write pointer go to 0.
  - inflight goes to 0.
  - out_valid=0, pc_en=0, imem_rden=0.
  - out_instr and out_pc read 0.
  - Outputs stay in this state for the whole time rst=0, including when reset is asserted mid-fetch.
- Credit rule:
  - issue = !redirect && (count + inflight) < DEPTH.
  - Responses therefore can never overflow the FIFO.
- Outputs each cycle:
  - imem_rden = issue.
  - pc_en = issue | redirect.
  - imem_addr = pc_q[ADDR_W-1:0] (combinational).
- Issue registers: on every edge, inflight <= issue and inflight_pc <= pc_q.
- Push: when inflight=1 and redirect=0, write {inflight_pc, imem_q} at the write pointer and advance it.
- Pop: when out_valid && out_ready, advance the read pointer.
- Pointers wrap modulo DEPTH.
- count is updated by push and pop; a simultaneous push and pop leaves count unchanged.
- out_valid = (count != 0) && !redirect.
- out_instr and out_pc show the head entry combinationally whenever count != 0.
- Redirect cycle:
  - Pointers and count clear to 0 at the edge.
  - Any in-flight response is discarded (no push).
  - No issue; pc_en=1 so the target loads into the PC register.
  - No handoff, since out_valid is forced low.
- First fetch after a redirect is issued the next cycle from the new pc_q.
- Redirect wins over a same-cycle push or pop; a pop attempted during redirect is not counted.
- Latency: issue in cycle N → push at the end of N+1 → out_valid in N+2.
- Throughput: one instruction per cycle is sustained while out_ready=1.
- Full: when count + inflight = DEPTH, issue=0 and pc_en=0, which freezes the PC.
- Empty: out_valid=0; out_instr/out_pc are don't-care.
- Backpressure (out_ready=0): the head entry is held stable until accepted.
- Address width: PC bits above ADDR_W are ignored for addressing but are preserved in out_pc.

Decomposition:
- Shared package (cpu_pkg):
  - instruction width constant INSTR_W=32 and PC width constant PC_W=32.
  - fetch entry struct {pc, instr}.
- One natural sub-module: sync_fifo (DEPTH x (PC_W+DATA_W)).
  - Has push, pop, flush, count, and a head read port.
  - fetch_queue holds the credit/inflight logic and instantiates sync_fifo.

Test Plan:
- Reset then release with out_ready=1 and pc_q stepping 0,1,2… driven by pc_en → imem_rden high from cycle 0; first out_valid two cycles later with out_pc=0 and out_instr=mem[0]; then one instruction per cycle in order.
- out_ready=0 from start, DEPTH=4 → exactly 4 issues, pc_en falls to 0, occupancy=4, pc_q frozen at 4; raising out_ready resumes at pc 4 with no gaps or duplicates.
- redirect pulse while occupancy=3 and inflight=1, target 0x40 → same cycle out_valid=0 and pc_en=1; next cycle occupancy=0 and the fetch is at 0x40; first delivered out_pc=0x40 and the stale response is never delivered.
- redirect coinciding with out_ready=1 on a non-empty queue → no handoff counted; occupancy=0 after the edge.
- Assert rst low mid-stream with a read in flight → all outputs drop to 0 immediately; after release the returning imem_q is ignored and occupancy stays 0 until a new issue.
- Toggle out_ready randomly over 1000 cycles with random redirects → scoreboard confirms delivered PCs are consecutive between redirects and each instr equals mem[pc].
